// File: rtl/rx_stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : rx_stream_mux_pkg
// Brief  : Shared FSM encoding, tag magic and width helpers for rx_stream_mux.
// Rev    : 1.0  initial release
// ============================================================================
package rx_stream_mux_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PULL  = 3'd1,
      ST_LATCH = 3'd2,
      ST_TAG   = 3'd3,
      ST_SEND  = 3'd4
   } state_t;

   localparam logic [3:0] TAG_MAGIC = 4'b1010;

   // max(1, clog2(n)): index width that stays legal for n = 1
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rx_stream_mux_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector; first set mask bit above i_last.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_CH = 2,
   parameter int CH_W   = 1
) (
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [CH_W-1:0]   i_last,
   output logic              o_found,
   output logic [CH_W-1:0]   o_idx
);

   always_comb begin
      int  idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      o_idx   = '0;
      for (int off = 1; off <= NUM_CH; off++) begin
         idx = (int'(i_last) + off) % NUM_CH;
         if (!found && i_mask[idx]) begin
            found = 1'b1;
            o_idx = CH_W'(idx);
         end
      end
      o_found = found;
   end

endmodule
`default_nettype wire

// File: rtl/rx_stream_mux.sv
`default_nettype none
// ============================================================================
// Module : rx_stream_mux
// Brief  : Pulls samples from NUM_CH FIFOs and serialises them MSB-beat-first
//          onto a valid/ready bus. RX_STREAM_MUX_TAG_EN adds a channel tag beat.
// Rev    : 1.0  initial release
// ============================================================================
module rx_stream_mux
   import rx_stream_mux_pkg::*;
#(
   parameter  int NUM_CH   = 2,
   parameter  int SAMPLE_W = 32,
   parameter  int BUS_W    = 8,
   localparam int CH_W     = ch_width(NUM_CH)
) (
   input  logic                       i_sys_clk,
   input  logic                       i_rst_b,
   input  logic [NUM_CH-1:0]          i_ch_enable,
   input  logic                       i_rr_mode,
   input  logic [CH_W-1:0]            i_fixed_ch,
   input  logic [NUM_CH-1:0]          i_fifo_empty,
   output logic [NUM_CH-1:0]          o_fifo_pull,
   input  logic [NUM_CH*SAMPLE_W-1:0] i_fifo_data,
   output logic [BUS_W-1:0]           o_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic                       o_sof,
   output logic [CH_W-1:0]            o_ch_id,
   output logic                       o_busy
);

   localparam int BEATS  = SAMPLE_W / BUS_W;
   localparam int BEAT_W = ch_width(BEATS);

   state_t              state_q, state_d;
   logic [CH_W-1:0]     sel_q, sel_d;
   logic [CH_W-1:0]     rr_q, rr_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;

   logic [NUM_CH-1:0]   eligible;
   logic [NUM_CH-1:0]   fixed_hot;
   logic [NUM_CH-1:0]   pick_mask;
   logic                pick_found;
   logic [CH_W-1:0]     pick_idx;

   // Fixed mode reuses the round-robin picker with a one-hot mask; an
   // out-of-range i_fixed_ch matches no bit and is therefore never eligible.
   always_comb begin
      eligible  = i_ch_enable & ~i_fifo_empty;
      fixed_hot = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         fixed_hot[k] = (int'(i_fixed_ch) == k);
      end
      pick_mask = i_rr_mode ? eligible : (eligible & fixed_hot);
   end

   rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_pick (
      .i_mask  (pick_mask),
      .i_last  (rr_q),
      .o_found (pick_found),
      .o_idx   (pick_idx)
   );

`ifdef RX_STREAM_MUX_TAG_EN
   logic [BUS_W-1:0] tag_beat;
   always_comb begin
      tag_beat                  = '0;
      tag_beat[BUS_W-1 -: 4]    = TAG_MAGIC;
      tag_beat[CH_W-1:0]        = sel_q;
   end
`endif

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rr_d        = rr_q;
      sample_d    = sample_q;
      beat_d      = beat_q;
      o_fifo_pull = '0;
      o_valid     = 1'b0;
      o_data      = '0;
      o_sof       = 1'b0;
      o_ch_id     = '0;
      o_busy      = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               state_d = ST_PULL;
            end
         end
         ST_PULL: begin
            for (int k = 0; k < NUM_CH; k++) begin
               o_fifo_pull[k] = (sel_q == CH_W'(k));
            end
            rr_d    = sel_q;
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (sel_q == CH_W'(k)) sample_d = i_fifo_data[k*SAMPLE_W +: SAMPLE_W];
            end
            beat_d  = '0;
            o_ch_id = sel_q;
`ifdef RX_STREAM_MUX_TAG_EN
            state_d = ST_TAG;
`else
            state_d = ST_SEND;
`endif
         end
`ifdef RX_STREAM_MUX_TAG_EN
         ST_TAG: begin
            o_valid = 1'b1;
            o_sof   = 1'b1;
            o_ch_id = sel_q;
            o_data  = tag_beat;
            if (i_ready) state_d = ST_SEND;
         end
`endif
         ST_SEND: begin
            o_valid = 1'b1;
            o_ch_id = sel_q;
            o_data  = sample_q[SAMPLE_W-1 -: BUS_W];
`ifdef RX_STREAM_MUX_TAG_EN
            o_sof   = 1'b0;
`else
            o_sof   = (beat_q == '0);
`endif
            // The sample register shifts out MSB-first on each accepted beat
            if (i_ready) begin
               sample_d = sample_q << BUS_W;
               if (beat_q == BEAT_W'(BEATS-1)) state_d = ST_IDLE;
               else                            beat_d  = beat_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_rst_b) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         rr_q     <= CH_W'(NUM_CH-1);
         sample_q <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         rr_q     <= rr_d;
         sample_q <= sample_d;
         beat_q   <= beat_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rx_stream_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_rx_stream_mux
// Brief  : Directed plus randomized self-checking bench for rx_stream_mux.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rx_stream_mux;

   localparam int NUM_CH   = 2;
   localparam int SAMPLE_W = 32;
   localparam int BUS_W    = 8;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [1:0]  ch_enable;
   logic        rr_mode;
   logic [0:0]  fixed_ch;
   logic [1:0]  fifo_empty;
   logic [1:0]  fifo_pull;
   logic [63:0] fifo_data;
   logic [7:0]  data;
   logic        valid;
   logic        ready;
   logic        sof;
   logic [0:0]  ch_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int model_last;

   always #5 clk = ~clk;

   rx_stream_mux #(
      .NUM_CH   (NUM_CH),
      .SAMPLE_W (SAMPLE_W),
      .BUS_W    (BUS_W)
   ) dut (
      .i_sys_clk    (clk),
      .i_rst_b      (rst_b),
      .i_ch_enable  (ch_enable),
      .i_rr_mode    (rr_mode),
      .i_fixed_ch   (fixed_ch),
      .i_fifo_empty (fifo_empty),
      .o_fifo_pull  (fifo_pull),
      .i_fifo_data  (fifo_data),
      .o_data       (data),
      .o_valid      (valid),
      .i_ready      (ready),
      .o_sof        (sof),
      .o_ch_id      (ch_id),
      .o_busy       (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Channel the spec's selection rules choose from the current inputs, or -1
   function automatic int predict();
      if (rr_mode) begin
         for (int off = 1; off <= NUM_CH; off++) begin
            int c;
            c = (model_last + off) % NUM_CH;
            if (ch_enable[c] && !fifo_empty[c]) return c;
         end
         return -1;
      end
      if (int'(fixed_ch) < NUM_CH && ch_enable[fixed_ch] && !fifo_empty[fixed_ch])
         return int'(fixed_ch);
      return -1;
   endfunction

   // action: 0 none, 1 disable ch0 at action_beat, 2 reset at action_beat
   task automatic do_sample(input int exp_ch, input logic [31:0] word, input int ready_pct,
                            input int stall_beat, input int action, input int action_beat);
      logic [7:0] exp_q[$];
      logic [1:0] exp_pull;
      int         n, idx, budget, stalls;
      bit         got;
      exp_q = {};
`ifdef RX_STREAM_MUX_TAG_EN
      exp_q.push_back(8'hA0 | 8'(exp_ch));
`endif
      for (int b = 0; b < SAMPLE_W/BUS_W; b++) exp_q.push_back(word[31-8*b -: 8]);
      exp_pull = 2'b01 << exp_ch;

      n = 0; got = 1'b0;
      while (!got && n < 12) begin
         if (fifo_pull != '0) got = 1'b1;
         else begin
            step();
            n++;
         end
      end
      check("pull_seen", 64'(got), 64'd1);
      if (!got) return;
      check("pull_onehot", 64'(fifo_pull), 64'(exp_pull));
      check("pull_busy", 64'(busy), 64'd1);
      model_last = exp_ch;
      step();
      check("pull_single", 64'(fifo_pull), 64'd0);
      check("latch_ch_id", 64'(ch_id), 64'(exp_ch));
      check("latch_novalid", 64'(valid), 64'd0);
      step();

      idx = 0; budget = 0; stalls = 0;
      while (idx < exp_q.size() && budget < 200) begin
         if (action == 1 && idx == action_beat) ch_enable[0] = 1'b0;
         check("beat_valid", 64'(valid), 64'd1);
         check("beat_data", 64'(data), 64'(exp_q[idx]));
         check("beat_sof", 64'(sof), 64'(idx == 0));
         check("beat_ch_id", 64'(ch_id), 64'(exp_ch));
         check("beat_nopull", 64'(fifo_pull), 64'd0);
         if (action == 2 && idx == action_beat) begin
            rst_b = 1'b0;
            step();
            check("rst_valid", 64'(valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            repeat (2) begin
               step();
               check("rst_nopull", 64'(fifo_pull), 64'd0);
            end
            rst_b      = 1'b1;
            model_last = NUM_CH - 1;
            return;
         end
         if (idx == stall_beat && stalls < 5) begin
            ready = 1'b0;
            stalls++;
         end else begin
            ready = ($urandom % 100) < ready_pct;
         end
         if (ready) idx++;
         step();
         budget++;
      end
      check("beats_done", 64'(idx), 64'(exp_q.size()));
      check("end_idle", 64'(valid), 64'd0);
      ready = 1'b1;
   endtask

   initial begin
      int          pred;
      logic [31:0] w;

      rst_b      = 1'b0;
      ch_enable  = 2'b11;
      rr_mode    = 1'b1;
      fixed_ch   = 1'b0;
      fifo_empty = 2'b00;
      fifo_data  = {32'h55667788, 32'h11223344};
      ready      = 1'b1;
      model_last = NUM_CH - 1;

      // T1 reset held two cycles with every FIFO non-empty
      repeat (2) begin
         step();
         check("reset_valid", 64'(valid), 64'd0);
         check("reset_pull", 64'(fifo_pull), 64'd0);
         check("reset_busy", 64'(busy), 64'd0);
         check("reset_sof", 64'(sof), 64'd0);
         check("reset_ch_id", 64'(ch_id), 64'd0);
      end
      rst_b = 1'b1;

      // T3 round-robin alternation, ch0 first
      for (int i = 0; i < 4; i++)
         do_sample(i % 2, (i % 2) ? 32'h55667788 : 32'h11223344, 100, -1, 0, 0);

      // T2 fixed ch1
      rr_mode   = 1'b0;
      fixed_ch  = 1'b1;
      fifo_data = {32'hDEADBEEF, 32'h11223344};
      do_sample(1, 32'hDEADBEEF, 100, -1, 0, 0);

      // T4 five-cycle stall at beat 2
      do_sample(1, 32'hDEADBEEF, 100, 2, 0, 0);

      // T5 disable ch0 mid-sample, then reset mid-sample
      rr_mode = 1'b1;
      do_sample(0, 32'h11223344, 100, -1, 1, 1);
      do_sample(1, 32'hDEADBEEF, 100, -1, 0, 0);
      ch_enable = 2'b11;
      do_sample(0, 32'h11223344, 100, -1, 2, 2);

      // T6 tag beat (or plain 4 beats without the macro)
      rr_mode   = 1'b0;
      fixed_ch  = 1'b1;
      fifo_data = {32'hCAFEF00D, 32'h11223344};
      do_sample(1, 32'hCAFEF00D, 100, -1, 0, 0);

      // Randomized settings against the selection model
      for (int it = 0; it < 24; it++) begin
         rr_mode    = 1'($urandom);
         fixed_ch   = 1'($urandom);
         ch_enable  = 2'($urandom);
         fifo_empty = 2'($urandom);
         fifo_data  = {$urandom, $urandom};
         pred       = predict();
         if (pred < 0) begin
            repeat (4) begin
               step();
               check("idle_nopull", 64'(fifo_pull), 64'd0);
               check("idle_busy", 64'(busy), 64'd0);
            end
         end else begin
            w = fifo_data[pred*32 +: 32];
            do_sample(pred, w, 30 + int'($urandom % 71), -1, 0, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
